// File: rtl/branch_predictor_if.sv
// Pipeline-side connection of the branch predictor: FD-stage lookup,
// FD->X prediction handoff and X-stage resolution.
interface branch_predictor_if;
  logic [31:0] fd_pc;
  logic        fd_is_branch;
  logic        stall;
  logic        flush;
  logic        pred_taken_fd;
  logic        pred_taken;
  logic [31:0] x_pc;
  logic        x_is_branch;
  logic        x_br_taken;

  modport master (
    output fd_pc, fd_is_branch, stall, flush, x_pc, x_is_branch, x_br_taken,
    input  pred_taken_fd, pred_taken
  );

  modport slave (
    input  fd_pc, fd_is_branch, stall, flush, x_pc, x_is_branch, x_br_taken,
    output pred_taken_fd, pred_taken
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: table of 2-bit saturating counters,
// optional gshare history, FD->X prediction register and perf counters.
module branch_predictor #(
  parameter int ENTRIES   = 64,
  parameter int HIST_BITS = 0,
  parameter int CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                bp_enable,
  branch_predictor_if.slave   bp,
  output logic [CNT_W-1:0]    branch_count,
  output logic [CNT_W-1:0]    mispredict_count
);

  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       ctr_r [ENTRIES];
  logic [GW-1:0]    ghr_r;
  logic [GW-1:0]    ghr_nxt_s;
  logic [IW-1:0]    fd_idx_s;
  logic [IW-1:0]    x_idx_s;
  logic [1:0]       x_ctr_nxt_s;
  logic             pred_fd_s;
  logic             pred_taken_r;
  logic [CNT_W-1:0] branch_cnt_r;
  logic [CNT_W-1:0] mispred_cnt_r;

  function automatic logic [IW-1:0] idx_f(input logic [31:0] pc, input logic [GW-1:0] ghr);
    logic [IW-1:0] hist;
    if (HIST_BITS > 0) begin
      hist = IW'(ghr);
    end else begin
      hist = {IW{1'b0}};
    end
    return pc[IW+1:2] ^ hist;
  endfunction

  function automatic logic [1:0] sat_f(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    case ({taken, ctr})
      3'b1_11: res = 2'b11;
      3'b0_00: res = 2'b00;
      3'b1_00, 3'b1_01, 3'b1_10: res = ctr + 2'b01;
      3'b0_01, 3'b0_10, 3'b0_11: res = ctr - 2'b01;
      default: res = ctr;
    endcase
    return res;
  endfunction

  // Lookup, training index and next history; training sees the pre-edge ghr.
  always_comb begin
    fd_idx_s    = idx_f(bp.fd_pc, ghr_r);
    x_idx_s     = idx_f(bp.x_pc, ghr_r);
    x_ctr_nxt_s = sat_f(ctr_r[x_idx_s], bp.x_br_taken);
    pred_fd_s   = bp_enable & bp.fd_is_branch & ctr_r[fd_idx_s][1];
    if (HIST_BITS > 0) begin
      ghr_nxt_s = GW'({ghr_r, bp.x_br_taken});
    end else begin
      ghr_nxt_s = ghr_r;
    end
  end

  // Counter table: every entry resets to weakly not-taken; no same-cycle bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (bp.x_is_branch) begin
      ctr_r[x_idx_s] <= x_ctr_nxt_s;
    end
  end

  // Global history, shifted only on resolved branches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_r <= {GW{1'b0}};
    end else if (bp.x_is_branch) begin
      ghr_r <= ghr_nxt_s;
    end
  end

  // FD->X prediction register: flush beats stall beats load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_taken_r <= 1'b0;
    end else if (bp.flush) begin
      pred_taken_r <= 1'b0;
    end else if (!bp.stall) begin
      pred_taken_r <= pred_fd_s;
    end
  end

  // Performance counters; wrap freely and ignore stall/flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_r  <= {CNT_W{1'b0}};
      mispred_cnt_r <= {CNT_W{1'b0}};
    end else if (bp.x_is_branch) begin
      branch_cnt_r <= branch_cnt_r + CNT_ONE;
      if (bp.x_br_taken != pred_taken_r) begin
        mispred_cnt_r <= mispred_cnt_r + CNT_ONE;
      end
    end
  end

  assign bp.pred_taken_fd  = pred_fd_s;
  assign bp.pred_taken     = pred_taken_r;
  assign branch_count      = branch_cnt_r;
  assign mispredict_count  = mispred_cnt_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench: bimodal instance (64 entries, 4-bit perf
// counters) plus a small gshare instance (16 entries, 2 history bits).
module tb_branch_predictor;

  logic clk;
  logic rst_n;
  logic bp_enable;
  logic [3:0] branch_count;
  logic [3:0] mispredict_count;
  logic [7:0] gs_branch_count;
  logic [7:0] gs_mispredict_count;
  int checks;
  int failures;

  branch_predictor_if bpi ();
  branch_predictor_if gsi ();

  branch_predictor #(.ENTRIES(64), .HIST_BITS(0), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .bp_enable(bp_enable), .bp(bpi.slave),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  branch_predictor #(.ENTRIES(16), .HIST_BITS(2), .CNT_W(8)) u_gs (
    .clk(clk), .rst_n(rst_n), .bp_enable(bp_enable), .bp(gsi.slave),
    .branch_count(gs_branch_count), .mispredict_count(gs_mispredict_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken);
    bpi.x_pc = pc;
    bpi.x_br_taken = taken;
    bpi.x_is_branch = 1'b1;
    tick();
    bpi.x_is_branch = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bp_enable = 1'b1;
    bpi.fd_pc = 32'h0; bpi.fd_is_branch = 1'b0; bpi.stall = 1'b0; bpi.flush = 1'b0;
    bpi.x_pc = 32'h0; bpi.x_is_branch = 1'b0; bpi.x_br_taken = 1'b0;
    gsi.fd_pc = 32'h0; gsi.fd_is_branch = 1'b0; gsi.stall = 1'b0; gsi.flush = 1'b0;
    gsi.x_pc = 32'h0; gsi.x_is_branch = 1'b0; gsi.x_br_taken = 1'b0;
    #12 rst_n = 1'b1;
    tick();

    // 1: reset state
    bpi.fd_pc = 32'h100; bpi.fd_is_branch = 1'b1;
    #1;
    check_eq("rst_pred_fd", {31'b0, bpi.pred_taken_fd}, 32'd0);
    check_eq("rst_pred_x", {31'b0, bpi.pred_taken}, 32'd0);
    check_eq("rst_brcnt", {28'b0, branch_count}, 32'd0);
    check_eq("rst_miscnt", {28'b0, mispredict_count}, 32'd0);

    // 2: saturating counter on 0x100 while FD keeps looking it up
    resolve(32'h100, 1'b1);
    check_eq("sat_first_up", {31'b0, bpi.pred_taken_fd}, 32'd1);
    check_eq("sat_x_lag", {31'b0, bpi.pred_taken}, 32'd0);
    resolve(32'h100, 1'b1);
    check_eq("sat_x_load", {31'b0, bpi.pred_taken}, 32'd1);
    for (int i = 0; i < 4; i++) resolve(32'h100, 1'b1);
    check_eq("sat_hold_11", {31'b0, bpi.pred_taken_fd}, 32'd1);
    resolve(32'h100, 1'b0);
    check_eq("sat_11_to_10", {31'b0, bpi.pred_taken_fd}, 32'd1);
    resolve(32'h100, 1'b0);
    check_eq("sat_10_to_01", {31'b0, bpi.pred_taken_fd}, 32'd0);
    check_eq("sat_brcnt", {28'b0, branch_count}, 32'd8);
    check_eq("sat_miscnt", {28'b0, mispredict_count}, 32'd4);

    // 3: aliasing (0x200 shares index 0 with 0x100)
    resolve(32'h100, 1'b1);
    resolve(32'h100, 1'b1);
    bpi.fd_pc = 32'h200; #1;
    check_eq("alias_200", {31'b0, bpi.pred_taken_fd}, 32'd1);
    bpi.fd_pc = 32'h104; #1;
    check_eq("alias_104", {31'b0, bpi.pred_taken_fd}, 32'd0);

    // 4: same-cycle lookup and update, no bypass
    bpi.fd_pc = 32'h40;
    bpi.x_pc = 32'h40; bpi.x_br_taken = 1'b1; bpi.x_is_branch = 1'b1;
    #1;
    check_eq("same_cyc_old", {31'b0, bpi.pred_taken_fd}, 32'd0);
    tick();
    bpi.x_is_branch = 1'b0;
    #1;
    check_eq("same_cyc_new", {31'b0, bpi.pred_taken_fd}, 32'd1);
    check_eq("same_cyc_x", {31'b0, bpi.pred_taken}, 32'd0);

    // 5: stall hold, flush priority, bp_enable gating
    tick();
    check_eq("pipe_load", {31'b0, bpi.pred_taken}, 32'd1);
    bpi.stall = 1'b1; bpi.fd_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("pipe_stall", {31'b0, bpi.pred_taken}, 32'd1);
    end
    bpi.fd_pc = 32'h40; bpi.flush = 1'b1;
    tick();
    check_eq("pipe_flush", {31'b0, bpi.pred_taken}, 32'd0);
    bpi.flush = 1'b0; bpi.stall = 1'b0;
    resolve(32'h40, 1'b1);
    bp_enable = 1'b0; #1;
    check_eq("dis_pred_fd", {31'b0, bpi.pred_taken_fd}, 32'd0);
    tick();
    check_eq("dis_pred_x", {31'b0, bpi.pred_taken}, 32'd0);
    bp_enable = 1'b1; #1;
    check_eq("reen_pred_fd", {31'b0, bpi.pred_taken_fd}, 32'd1);

    // 6: 4-bit counters wrap; then asynchronous reset between edges
    bpi.fd_is_branch = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) resolve(32'h300, (i < 5) ? 1'b1 : 1'b0);
    check_eq("wrap_brcnt", {28'b0, branch_count}, 32'd1);
    check_eq("wrap_miscnt", {28'b0, mispredict_count}, 32'd5);
    for (int i = 0; i < 3; i++) resolve(32'h300, 1'b1);
    bpi.fd_pc = 32'h300; bpi.fd_is_branch = 1'b1;
    tick();
    check_eq("pre_arst_x", {31'b0, bpi.pred_taken}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_pred_x", {31'b0, bpi.pred_taken}, 32'd0);
    check_eq("arst_pred_fd", {31'b0, bpi.pred_taken_fd}, 32'd0);
    check_eq("arst_brcnt", {28'b0, branch_count}, 32'd0);
    check_eq("arst_miscnt", {28'b0, mispredict_count}, 32'd0);
    check_eq("arst_tbl_0", {30'b0, u_dut.ctr_r[0]}, 32'd1);
    check_eq("arst_tbl_16", {30'b0, u_dut.ctr_r[16]}, 32'd1);
    check_eq("arst_tbl_63", {30'b0, u_dut.ctr_r[63]}, 32'd1);
    bpi.fd_is_branch = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // gshare: index = pc[5:2] ^ ghr
    gsi.fd_is_branch = 1'b1;
    gsi.x_pc = 32'h0; gsi.x_br_taken = 1'b1; gsi.x_is_branch = 1'b1;
    tick();
    gsi.fd_pc = 32'h0; #1;
    check_eq("gs_h1_pc0", {31'b0, gsi.pred_taken_fd}, 32'd0);
    gsi.fd_pc = 32'h4; #1;
    check_eq("gs_h1_pc4", {31'b0, gsi.pred_taken_fd}, 32'd1);
    gsi.fd_is_branch = 1'b0;
    gsi.x_br_taken = 1'b0;
    tick();
    gsi.x_is_branch = 1'b0;
    gsi.fd_is_branch = 1'b1;
    gsi.fd_pc = 32'h8; #1;
    check_eq("gs_h2_pc8", {31'b0, gsi.pred_taken_fd}, 32'd1);
    gsi.fd_pc = 32'h0; #1;
    check_eq("gs_h2_pc0", {31'b0, gsi.pred_taken_fd}, 32'd0);
    check_eq("gs_brcnt", {24'b0, gs_branch_count}, 32'd2);
    check_eq("gs_miscnt", {24'b0, gs_mispredict_count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
